// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM state encoding and frame byte counts.
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERROR} state_t;
  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: shifts bytes MSB-first into a 32-bit word and flags the 4th byte.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d;
  always_comb begin
    cnt_d     = clr ? '0 : en ? cnt_q + 2'd1 : cnt_q;
    sr_d      = en ? {sr_q[23:0], din} : sr_q;
    word      = sr_d;
    word_full = en && (cnt_q == 2'(WORD_BYTES - 1));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream, writes it into IM and releases the CPU once the checksum verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);
  state_t        state_q, state_d;
  logic [15:0]   n_q, n_d;
  logic [AW-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [7:0]    acc_q, acc_d;
  logic [31:0]   wdata_q, wdata_d, word;
  logic          we_q, we_d, xfer, word_full;
  assign in_ready = state_q inside {HDR_HI, HDR_LO, DATA, CSUM};
  assign xfer     = in_valid && in_ready;
  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign cpu_hold = state_q != DONE;
  assign done     = state_q == DONE;
  assign err      = state_q == ERROR;
  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q != DATA),
    .en        (xfer && state_q == DATA),
    .din       (in_data),
    .word      (word),
    .word_full (word_full)
  );
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    acc_d   = xfer ? acc_q ^ in_data : acc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE:   state_d = HDR_HI;
      HDR_HI: if (xfer) begin
        n_d     = {in_data, 8'h00};
        state_d = HDR_LO;
      end
      HDR_LO: if (xfer) begin
        n_d     = {n_q[15:8], in_data};
        idx_d   = '0;
        state_d = n_d > 16'(DEPTH) ? ERROR : n_d == 16'd0 ? CSUM : DATA;
      end
      DATA: if (word_full) begin
        we_d    = 1'b1;
        addr_d  = idx_q;
        wdata_d = word;
        idx_d   = idx_q + AW'(1);
        if (16'(idx_q) == n_q - 16'd1) state_d = CSUM;
      end
      CSUM:   if (xfer) state_d = (acc_q ^ in_data) == 8'h00 ? DONE : ERROR;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule
